// File: rtl/scr1_tcm_pkg.sv
// Shared types and helpers for the TCM controller: response codes, LSU command
// and width encodings, and the lane/alignment helpers used on port B.
package scr1_tcm_pkg;

    typedef enum logic [1:0] {
        TCM_RESP_IDLE = 2'b00,
        TCM_RESP_RDY  = 2'b01,
        TCM_RESP_ER   = 2'b10
    } tcm_resp_e;

    typedef enum logic {
        TCM_CMD_RD = 1'b0,
        TCM_CMD_WR = 1'b1
    } tcm_cmd_e;

    typedef enum logic [1:0] {
        TCM_WIDTH_BYTE  = 2'd0,
        TCM_WIDTH_HWORD = 2'd1,
        TCM_WIDTH_WORD  = 2'd2
    } tcm_width_e;

    // Width code 3 is not a legal access and is treated as misaligned.
    function automatic logic tcm_misaligned(input logic [1:0] width, input logic [1:0] off);
        logic mis;
        case (width)
            TCM_WIDTH_BYTE:  mis = 1'b0;
            TCM_WIDTH_HWORD: mis = off[0];
            TCM_WIDTH_WORD:  mis = (off != 2'b00);
            default:         mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] tcm_be(input logic [1:0] width, input logic [1:0] off);
        logic [3:0] be;
        case (width)
            TCM_WIDTH_BYTE:  be = 4'b0001 << off;
            TCM_WIDTH_HWORD: be = 4'b0011 << off;
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicating the right-aligned data lets the byte enables alone pick the lane.
    function automatic logic [31:0] tcm_repl(input logic [1:0] width, input logic [31:0] wdata);
        logic [31:0] d;
        case (width)
            TCM_WIDTH_BYTE:  d = {4{wdata[7:0]}};
            TCM_WIDTH_HWORD: d = {2{wdata[15:0]}};
            default:         d = wdata;
        endcase
        return d;
    endfunction

    // Right-align the addressed lanes and zero-extend; sign extension is left to the LSU.
    function automatic logic [31:0] tcm_align_rdata(input logic [1:0] width, input logic [1:0] off,
                                                    input logic [31:0] q);
        logic [31:0] s;
        logic [31:0] d;
        s = q >> {off, 3'b000};
        case (width)
            TCM_WIDTH_BYTE:  d = {24'h000000, s[7:0]};
            TCM_WIDTH_HWORD: d = {16'h0000, s[15:0]};
            default:         d = s;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/scr1_tcm_if.sv
// Core-side request/response bundle of the TCM controller: instruction fetch,
// LSU and system/debug initiators. master = requesters, slave = controller.
interface scr1_tcm_if #(
    parameter int AW = 16
);
    logic          imem_req;
    logic          imem_req_ack;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic [1:0]    imem_resp;

    logic          dmem_req;
    logic          dmem_cmd;
    logic [1:0]    dmem_width;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_req_ack;
    logic [31:0]   dmem_rdata;
    logic [1:0]    dmem_resp;

    logic          sys_req;
    logic          sys_cmd;
    logic [3:0]    sys_be;
    logic [AW-1:0] sys_addr;
    logic [31:0]   sys_wdata;
    logic          sys_req_ack;
    logic [31:0]   sys_rdata;
    logic [1:0]    sys_resp;

    modport master (
        output imem_req, imem_addr,
        input  imem_req_ack, imem_rdata, imem_resp,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp,
        output sys_req, sys_cmd, sys_be, sys_addr, sys_wdata,
        input  sys_req_ack, sys_rdata, sys_resp
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_req_ack, imem_rdata, imem_resp,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp,
        input  sys_req, sys_cmd, sys_be, sys_addr, sys_wdata,
        output sys_req_ack, sys_rdata, sys_resp
    );
endinterface

// File: rtl/scr1_tcm_portb_arb.sv
// Port B arbiter between the LSU (dmem) and the system initiator (sys).
// Build option SCR1_TCM_ARB_RR_EN: two-way round-robin with a last-grant bit;
// otherwise fixed priority dmem > sys with no state.
module scr1_tcm_portb_arb (
`ifdef SCR1_TCM_ARB_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic dmem_req,
    input  logic sys_req,
    output logic grant_dmem,
    output logic grant_sys
);

`ifdef SCR1_TCM_ARB_RR_EN
    logic last_dmem;

    // On a tie, hand the port to whichever side did not get it last time.
    always_comb begin
        grant_dmem = dmem_req && (!sys_req || !last_dmem);
        grant_sys  = sys_req && !grant_dmem;
    end

    // Last-grant pointer; resets to "sys last" so dmem wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dmem <= 1'b0;
        end else if (grant_dmem || grant_sys) begin
            last_dmem <= grant_dmem;
        end
    end
`else
    // Fixed priority: the LSU always beats the system initiator.
    always_comb begin
        grant_dmem = dmem_req;
        grant_sys  = sys_req && !dmem_req;
    end
`endif

endmodule

// File: rtl/scr1_tcm_ctrl.sv
// TCM controller in front of a dual-port byte-enabled synchronous RAM.
// Port A serves instruction fetch; port B is shared by the LSU and the system
// initiator. Responses are single-cycle registered pulses one cycle after accept.
// Build option SCR1_TCM_ARB_RR_EN selects round-robin port B arbitration.
module scr1_tcm_ctrl
    import scr1_tcm_pkg::*;
#(
    parameter int SCR1_TCM_AW = 16,
    parameter int SCR1_TCM_DW = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    scr1_tcm_if.slave              bus,
    output logic                   mem_rena,
    output logic [SCR1_TCM_AW-1:0] mem_addra,
    input  logic [SCR1_TCM_DW-1:0] mem_qa,
    output logic                   mem_renb,
    output logic                   mem_wenb,
    output logic [3:0]             mem_webb,
    output logic [SCR1_TCM_AW-1:0] mem_addrb,
    output logic [SCR1_TCM_DW-1:0] mem_datab,
    input  logic [SCR1_TCM_DW-1:0] mem_qb
);

    logic       imem_ok;
    logic       dmem_mis;
    logic       grant_dmem;
    logic       grant_sys;

    tcm_resp_e  imem_resp_q;
    tcm_resp_e  dmem_resp_q;
    tcm_resp_e  sys_resp_q;
    logic       dmem_rd_q;
    logic       sys_rd_q;
    logic [1:0] dmem_off_q;
    logic [1:0] dmem_width_q;

    scr1_tcm_portb_arb u_arb (
`ifdef SCR1_TCM_ARB_RR_EN
        .clk        (clk),
        .rst_n      (rst_n),
`endif
        .dmem_req   (bus.dmem_req),
        .sys_req    (bus.sys_req),
        .grant_dmem (grant_dmem),
        .grant_sys  (grant_sys)
    );

    // Port A: fetch is always accepted; only word-aligned fetches touch the RAM.
    always_comb begin
        bus.imem_req_ack = bus.imem_req;
        imem_ok          = bus.imem_req && (bus.imem_addr[1:0] == 2'b00);
        mem_rena         = imem_ok;
        mem_addra        = bus.imem_addr;
        dmem_mis         = tcm_misaligned(bus.dmem_width, bus.dmem_addr[1:0]);
        bus.dmem_req_ack = grant_dmem;
        bus.sys_req_ack  = grant_sys;
    end

    // Port B command mux: the granted initiator drives the RAM unless the access is dropped.
    always_comb begin
        mem_renb  = 1'b0;
        mem_wenb  = 1'b0;
        mem_webb  = 4'b0000;
        mem_addrb = '0;
        mem_datab = '0;
        if (grant_dmem) begin
            mem_addrb = bus.dmem_addr;
            mem_datab = tcm_repl(bus.dmem_width, bus.dmem_wdata);
            if (!dmem_mis) begin
                if (bus.dmem_cmd == TCM_CMD_WR) begin
                    mem_wenb = 1'b1;
                    mem_webb = tcm_be(bus.dmem_width, bus.dmem_addr[1:0]);
                end else begin
                    mem_renb = 1'b1;
                end
            end
        end else if (grant_sys) begin
            mem_addrb = bus.sys_addr;
            mem_datab = bus.sys_wdata;
            if (bus.sys_be != 4'b0000) begin
                if (bus.sys_cmd == TCM_CMD_WR) begin
                    mem_wenb = 1'b1;
                    mem_webb = bus.sys_be;
                end else begin
                    mem_renb = 1'b1;
                end
            end
        end
    end

    // Response sequencing: capture the outcome and read-alignment info at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_resp_q  <= TCM_RESP_IDLE;
            dmem_resp_q  <= TCM_RESP_IDLE;
            sys_resp_q   <= TCM_RESP_IDLE;
            dmem_rd_q    <= 1'b0;
            sys_rd_q     <= 1'b0;
            dmem_off_q   <= 2'b00;
            dmem_width_q <= 2'b00;
        end else begin
            imem_resp_q <= !bus.imem_req ? TCM_RESP_IDLE :
                           imem_ok       ? TCM_RESP_RDY  : TCM_RESP_ER;
            dmem_resp_q <= !grant_dmem   ? TCM_RESP_IDLE :
                           dmem_mis      ? TCM_RESP_ER   : TCM_RESP_RDY;
            sys_resp_q  <= grant_sys     ? TCM_RESP_RDY  : TCM_RESP_IDLE;
            dmem_rd_q   <= grant_dmem && !dmem_mis && (bus.dmem_cmd == TCM_CMD_RD);
            sys_rd_q    <= grant_sys && (bus.sys_be != 4'b0000) && (bus.sys_cmd == TCM_CMD_RD);
            if (grant_dmem) begin
                dmem_off_q   <= bus.dmem_addr[1:0];
                dmem_width_q <= bus.dmem_width;
            end
        end
    end

    // Read data is forced to zero unless the response is RDY for a read that reached the RAM.
    always_comb begin
        bus.imem_resp  = imem_resp_q;
        bus.dmem_resp  = dmem_resp_q;
        bus.sys_resp   = sys_resp_q;
        bus.imem_rdata = (imem_resp_q == TCM_RESP_RDY) ? mem_qa : 32'h0;
        bus.dmem_rdata = ((dmem_resp_q == TCM_RESP_RDY) && dmem_rd_q)
                         ? tcm_align_rdata(dmem_width_q, dmem_off_q, mem_qb) : 32'h0;
        bus.sys_rdata  = ((sys_resp_q == TCM_RESP_RDY) && sys_rd_q) ? mem_qb : 32'h0;
    end

endmodule

// File: tb/tb_scr1_tcm_ctrl.sv
// Directed bench for scr1_tcm_ctrl with a behavioural dual-port RAM.
module tb_scr1_tcm_ctrl;

    localparam int AW = 16;

    logic          clk;
    logic          rst_n;
    logic          mem_rena;
    logic [AW-1:0] mem_addra;
    logic [31:0]   mem_qa;
    logic          mem_renb;
    logic          mem_wenb;
    logic [3:0]    mem_webb;
    logic [AW-1:0] mem_addrb;
    logic [31:0]   mem_datab;
    logic [31:0]   mem_qb;

    logic [31:0]   ram [0:(1<<(AW-2))-1];

    int checks = 0;
    int errors = 0;

    scr1_tcm_if #(.AW(AW)) tcm_bus ();

    scr1_tcm_ctrl #(.SCR1_TCM_AW(AW), .SCR1_TCM_DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (tcm_bus),
        .mem_rena  (mem_rena),
        .mem_addra (mem_addra),
        .mem_qa    (mem_qa),
        .mem_renb  (mem_renb),
        .mem_wenb  (mem_wenb),
        .mem_webb  (mem_webb),
        .mem_addrb (mem_addrb),
        .mem_datab (mem_datab),
        .mem_qb    (mem_qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rena) mem_qa <= ram[mem_addra[AW-1:2]];
        if (mem_renb) mem_qb <= ram[mem_addrb[AW-1:2]];
        if (mem_wenb) begin
            for (int k = 0; k < 4; k++)
                if (mem_webb[k]) ram[mem_addrb[AW-1:2]][8*k +: 8] <= mem_datab[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        tcm_bus.imem_req   = 1'b0;
        tcm_bus.imem_addr  = '0;
        tcm_bus.dmem_req   = 1'b0;
        tcm_bus.dmem_cmd   = 1'b0;
        tcm_bus.dmem_width = 2'd0;
        tcm_bus.dmem_addr  = '0;
        tcm_bus.dmem_wdata = '0;
        tcm_bus.sys_req    = 1'b0;
        tcm_bus.sys_cmd    = 1'b0;
        tcm_bus.sys_be     = 4'b0000;
        tcm_bus.sys_addr   = '0;
        tcm_bus.sys_wdata  = '0;
    endtask

    task automatic sys_wr(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] data);
        @(negedge clk);
        idle();
        tcm_bus.sys_req   = 1'b1;
        tcm_bus.sys_cmd   = 1'b1;
        tcm_bus.sys_be    = be;
        tcm_bus.sys_addr  = addr;
        tcm_bus.sys_wdata = data;
        #1;
        chk("sys_wr_ack", {31'd0, tcm_bus.sys_req_ack}, 32'd1);
        chk("sys_wr_webb", {28'd0, mem_webb}, {28'd0, be});
        @(posedge clk); #1;
        chk("sys_wr_resp", {30'd0, tcm_bus.sys_resp}, 32'd1);
    endtask

    task automatic dmem_rd(input string tag, input logic [15:0] addr, input logic [1:0] width,
                           input logic [31:0] exp);
        @(negedge clk);
        idle();
        tcm_bus.dmem_req   = 1'b1;
        tcm_bus.dmem_cmd   = 1'b0;
        tcm_bus.dmem_width = width;
        tcm_bus.dmem_addr  = addr;
        #1;
        chk({tag, "_renb"}, {31'd0, mem_renb}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_resp"}, {30'd0, tcm_bus.dmem_resp}, 32'd1);
        chk({tag, "_rdata"}, tcm_bus.dmem_rdata, exp);
    endtask

    task automatic dmem_mis(input string tag, input logic cmd, input logic [15:0] addr,
                            input logic [1:0] width);
        @(negedge clk);
        idle();
        tcm_bus.dmem_req   = 1'b1;
        tcm_bus.dmem_cmd   = cmd;
        tcm_bus.dmem_width = width;
        tcm_bus.dmem_addr  = addr;
        tcm_bus.dmem_wdata = 32'h5555AAAA;
        #1;
        chk({tag, "_ack"}, {31'd0, tcm_bus.dmem_req_ack}, 32'd1);
        chk({tag, "_ram_en"}, {30'd0, mem_wenb, mem_renb}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_resp"}, {30'd0, tcm_bus.dmem_resp}, 32'd2);
        chk({tag, "_rdata"}, tcm_bus.dmem_rdata, 32'd0);
    endtask

    logic exp_d [3];
    logic exp_s [3];

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        chk("rst_imem_resp", {30'd0, tcm_bus.imem_resp}, 32'd0);
        chk("rst_dmem_resp", {30'd0, tcm_bus.dmem_resp}, 32'd0);
        chk("rst_sys_resp", {30'd0, tcm_bus.sys_resp}, 32'd0);
        chk("rst_rdata_or", tcm_bus.imem_rdata | tcm_bus.dmem_rdata | tcm_bus.sys_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload through the sys port
        sys_wr(16'h0100, 4'b1111, 32'h12345678);
        sys_wr(16'h0200, 4'b1111, 32'h00000000);
        sys_wr(16'h0300, 4'b1111, 32'h11112222);
        sys_wr(16'h0400, 4'b1111, 32'h00000000);

        // Arbitration: both request for three cycles; last grant was sys
`ifdef SCR1_TCM_ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 3; i++) exp_s[i] = !exp_d[i];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            tcm_bus.dmem_req   = 1'b1;
            tcm_bus.dmem_width = 2'd2;
            tcm_bus.dmem_addr  = 16'h0200;
            tcm_bus.sys_req    = 1'b1;
            tcm_bus.sys_be     = 4'b1111;
            tcm_bus.sys_addr   = 16'h0100;
            #1;
            chk("arb_dmem_ack", {31'd0, tcm_bus.dmem_req_ack}, {31'd0, exp_d[i]});
            chk("arb_sys_ack", {31'd0, tcm_bus.sys_req_ack}, {31'd0, exp_s[i]});
            @(posedge clk); #1;
            chk("arb_sys_resp", {30'd0, tcm_bus.sys_resp}, {31'd0, exp_s[i]});
            chk("arb_sys_rdata", tcm_bus.sys_rdata, exp_s[i] ? 32'h12345678 : 32'h0);
        end

        // imem aligned read
        @(negedge clk);
        idle();
        tcm_bus.imem_req  = 1'b1;
        tcm_bus.imem_addr = 16'h0100;
        #1;
        chk("imem_ack", {31'd0, tcm_bus.imem_req_ack}, 32'd1);
        chk("imem_rena", {31'd0, mem_rena}, 32'd1);
        chk("imem_addra", {16'd0, mem_addra}, 32'h0100);
        @(posedge clk); #1;
        chk("imem_resp", {30'd0, tcm_bus.imem_resp}, 32'd1);
        chk("imem_rdata", tcm_bus.imem_rdata, 32'h12345678);

        // imem misaligned
        @(negedge clk);
        tcm_bus.imem_addr = 16'h0102;
        #1;
        chk("imem_mis_ack", {31'd0, tcm_bus.imem_req_ack}, 32'd1);
        chk("imem_mis_rena", {31'd0, mem_rena}, 32'd0);
        @(posedge clk); #1;
        chk("imem_mis_resp", {30'd0, tcm_bus.imem_resp}, 32'd2);
        chk("imem_mis_rdata", tcm_bus.imem_rdata, 32'd0);

        // dmem byte write 0xAB at 0x0203
        @(negedge clk);
        idle();
        tcm_bus.dmem_req   = 1'b1;
        tcm_bus.dmem_cmd   = 1'b1;
        tcm_bus.dmem_width = 2'd0;
        tcm_bus.dmem_addr  = 16'h0203;
        tcm_bus.dmem_wdata = 32'h000000AB;
        #1;
        chk("bwr_ack", {31'd0, tcm_bus.dmem_req_ack}, 32'd1);
        chk("bwr_wenb", {31'd0, mem_wenb}, 32'd1);
        chk("bwr_webb", {28'd0, mem_webb}, 32'h8);
        chk("bwr_datab", mem_datab, 32'hABABABAB);
        @(posedge clk); #1;
        chk("bwr_resp", {30'd0, tcm_bus.dmem_resp}, 32'd1);
        chk("bwr_rdata", tcm_bus.dmem_rdata, 32'd0);

        dmem_rd("wrd", 16'h0200, 2'd2, 32'hAB000000);
        dmem_rd("brd", 16'h0203, 2'd0, 32'h000000AB);
        dmem_rd("hrd", 16'h0202, 2'd1, 32'h0000AB00);

        dmem_mis("hw_mis", 1'b1, 16'h0201, 2'd1);
        dmem_mis("w_mis", 1'b0, 16'h0202, 2'd2);
        dmem_mis("w3_mis", 1'b0, 16'h0200, 2'd3);

        // Same-word port A read and port B write
        @(negedge clk);
        idle();
        tcm_bus.imem_req   = 1'b1;
        tcm_bus.imem_addr  = 16'h0300;
        tcm_bus.dmem_req   = 1'b1;
        tcm_bus.dmem_cmd   = 1'b1;
        tcm_bus.dmem_width = 2'd2;
        tcm_bus.dmem_addr  = 16'h0300;
        tcm_bus.dmem_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("coll_old", tcm_bus.imem_rdata, 32'h11112222);
        chk("coll_wr_resp", {30'd0, tcm_bus.dmem_resp}, 32'd1);
        @(negedge clk);
        idle();
        tcm_bus.imem_req  = 1'b1;
        tcm_bus.imem_addr = 16'h0300;
        @(posedge clk); #1;
        chk("coll_new", tcm_bus.imem_rdata, 32'hDEADBEEF);

        // sys partial write with ignored low address bits, then raw read
        sys_wr(16'h0401, 4'b0110, 32'h00CDEF00);
        chk("sys_datab", mem_datab, 32'h00CDEF00);
        @(negedge clk);
        idle();
        tcm_bus.sys_req  = 1'b1;
        tcm_bus.sys_be   = 4'b1111;
        tcm_bus.sys_addr = 16'h0400;
        @(posedge clk); #1;
        chk("sys_rd_resp", {30'd0, tcm_bus.sys_resp}, 32'd1);
        chk("sys_rd_rdata", tcm_bus.sys_rdata, 32'h00CDEF00);

        // sys_be = 0: acked, no RAM access, RDY
        @(negedge clk);
        tcm_bus.sys_be = 4'b0000;
        #1;
        chk("sys_be0_ack", {31'd0, tcm_bus.sys_req_ack}, 32'd1);
        chk("sys_be0_ram_en", {30'd0, mem_wenb, mem_renb}, 32'd0);
        @(posedge clk); #1;
        chk("sys_be0_resp", {30'd0, tcm_bus.sys_resp}, 32'd1);
        chk("sys_be0_rdata", tcm_bus.sys_rdata, 32'd0);

        // Reset in the response cycle of an accepted read
        @(negedge clk);
        idle();
        tcm_bus.dmem_req   = 1'b1;
        tcm_bus.dmem_width = 2'd2;
        tcm_bus.dmem_addr  = 16'h0300;
        @(posedge clk); #1;
        chk("mid_rst_pre", {30'd0, tcm_bus.dmem_resp}, 32'd1);
        rst_n = 1'b0;
        idle();
        #1;
        chk("mid_rst_resp", {30'd0, tcm_bus.dmem_resp}, 32'd0);
        chk("mid_rst_rdata", tcm_bus.dmem_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_resp", {30'd0, tcm_bus.dmem_resp}, 32'd0);
        chk("post_rst_rdata", tcm_bus.dmem_rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scr1_tcm_ctrl.md
Name: scr1_tcm_ctrl

Overview:
Tightly-coupled-memory controller in front of the dual-port byte-enabled synchronous RAM.
- Port A is dedicated to core instruction fetch (imem).
- Port B is shared between the core LSU (dmem) and a system/debug initiator (sys). An arbiter grants one of them per cycle.
- Handles alignment checks, byte-lane generation, write-data replication, read-data alignment and single-cycle response sequencing.

Parameters:
SCR1_TCM_AW, 16, byte-address width of the TCM (log2 of size in bytes).
SCR1_TCM_DW, 32, data width; fixed at 32, 4 byte lanes.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
imem_req  in  1  fetch request
imem_req_ack  out  1  fetch request accepted
imem_addr  in  AW  fetch byte address
imem_rdata  out  32  fetch data
imem_resp  out  2  fetch response (IDLE/RDY/ER)
dmem_req  in  1  LSU request
dmem_cmd  in  1  0=read, 1=write
dmem_width  in  2  BYTE/HWORD/WORD
dmem_addr  in  AW  LSU byte address
dmem_wdata  in  32  LSU write data, right-aligned
dmem_req_ack  out  1  LSU request accepted
dmem_rdata  out  32  LSU read data, right-aligned
dmem_resp  out  2  LSU response
sys_req  in  1  system request
sys_cmd  in  1  0=read, 1=write
sys_be  in  4  system byte enables
sys_addr  in  AW  system address; bits [1:0] ignored
sys_wdata  in  32  system write data, lane-positioned
sys_req_ack  out  1  system request accepted
sys_rdata  out  32  system read data, raw word
sys_resp  out  2  system response
mem_rena  out  1  RAM port A read enable
mem_addra  out  AW  RAM port A address
mem_qa  in  32  RAM port A data, valid 1 cycle after rena
mem_renb  out  1  RAM port B read enable
mem_wenb  out  1  RAM port B write enable
mem_webb  out  4  RAM port B byte enables
mem_addrb  out  AW  RAM port B address
mem_datab  out  32  RAM port B write data
mem_qb  in  32  RAM port B data, valid 1 cycle after renb

Behaviour:
Handshake and timing
- Request/ack is combinational and same-cycle. A transfer occurs on a cycle where req=1 and ack=1.
- The response is a registered single-cycle pulse in cycle N+1. The requester must sample it; there is no backpressure.
- Back-to-back requests every cycle are supported on all three ports, giving a throughput of 1/cycle per RAM port.

Reset
- On reset, all resp registers go to IDLE, the grant pointer goes to "sys last" and the offset/width registers go to 0.
- *_rdata is 0 whenever the corresponding resp is not RDY.

imem (port A)
- imem_req_ack = imem_req.
- Address with addr[1:0]≠0: no RAM access; ER in N+1.
- Otherwise: mem_rena=1, mem_addra=imem_addr; RDY in N+1 with imem_rdata=mem_qa.

dmem alignment and lanes
- Misaligned access: HWORD with addr[0]=1, WORD with addr[1:0]≠0, or width=3.
- A misaligned request is acked, causes no RAM access, and gets ER in N+1.
- Byte enables: BYTE gives 4'b0001<<addr[1:0]; HWORD gives 4'b0011<<addr[1:0]; WORD gives 4'b1111.
- Write data: BYTE replicates {4{wdata[7:0]}}; HWORD replicates {2{wdata[15:0]}}; WORD passes through.

dmem reads
- The controller registers addr[1:0] and width at acceptance.
- N+1 data is mem_qb>>(8*offset), zero-extended to the access width.
- Sign extension is the LSU's job.

Writes (dmem and sys)
- RDY in N+1 with rdata=0.

sys port
- Word-granular; uses sys_be directly.
- sys_be=0 is acked with RDY and makes no RAM access.

Port B arbitration
- Only one of dmem/sys is acked per cycle; the loser's ack is 0 and it must hold its request.
- Default is fixed priority, dmem > sys.

Simultaneous events
- A port-A read and a port-B write to the same word in the same cycle: port A returns the old data.

Reset mid-transfer
- The pending response is dropped and resp is IDLE after reset release.

Optional Feature:
SCR1_TCM_ARB_RR_EN
- Defined: two-way round-robin on port B. When both request, the grant goes to the one not granted last. A 1-bit last-grant register updates on every port-B grant and resets to sys, so dmem wins the first tie.
- Undefined: fixed priority dmem > sys; no pointer register.

Decomposition:
Package scr1_tcm_pkg holds:
- resp enum IDLE=2'b00, RDY=2'b01, ER=2'b10.
- cmd enum RD/WR.
- width enum BYTE=0, HWORD=1, WORD=2.
- Byte-enable and replicate helper functions.

Sub-module scr1_tcm_portb_arb holds the grant logic and the optional round-robin pointer, with inputs dmem_req and sys_req and outputs grant_dmem and grant_sys.

Test Plan:
- imem_req, addr 0x0100, RAM word 0x12345678 -> ack same cycle, next cycle RDY, rdata 0x12345678. Addr 0x0102 -> ER, mem_rena=0.
- dmem BYTE write 0xAB at 0x0203 -> mem_webb=4'b1000, mem_datab=0xABABABAB, RDY next cycle. WORD read 0x0200 -> RDY, rdata 0xAB??????; BYTE read 0x0203 -> rdata 0x000000AB.
- dmem HWORD at 0x0201 and WORD at 0x0202 -> ER, mem_wenb=0, mem_renb=0.
- dmem and sys both request for 3 cycles. Without the macro: dmem acked 3×, sys 0×. With SCR1_TCM_ARB_RR_EN: grants dmem, sys, dmem.
- Port A read 0x0300 and port B WORD write 0xDEADBEEF to 0x0300 in the same cycle -> imem_rdata is the old value; next imem read returns 0xDEADBEEF.
- Assert rst_n low in the cycle after a dmem read is accepted -> dmem_resp=IDLE and rdata=0 immediately; no RDY after release.
